// File: rtl/tp_pkg.sv
// Shared types and constants for the multi-mode test pattern generator.
package tp_pkg;

    typedef enum logic [2:0] {
        TP_GRAD  = 3'd0,
        TP_BARS  = 3'd1,
        TP_CHECK = 3'd2,
        TP_GRID  = 3'd3,
        TP_SOLID = 3'd4,
        TP_BOX   = 3'd5,
        TP_RAMP  = 3'd6,
        TP_RSVD  = 3'd7
    } tp_mode_e;

    localparam int unsigned TP_NUM_BARS = 8;

    // {r,g,b} per bar, index 0 (left) = white ... index 7 = black
    localparam logic [7:0][2:0] TP_BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    // 8-bit background {r,g,b}; scaled to the channel width by MSB alignment
    localparam logic [23:0] TP_BG_RGB = 24'h001133;

endpackage

// File: rtl/tp_box_motion.sv
// Bouncing-box position/direction state, stepped once per frame boundary.
module tp_box_motion
    import tp_pkg::*;
#(
    parameter int unsigned CORDW     = 11,
    parameter int unsigned H_RES     = 1280,
    parameter int unsigned V_RES     = 720,
    parameter int unsigned BOX_SIZE  = 64,
    parameter int unsigned BOX_SPEED = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fb,
    output logic [CORDW-1:0] bx,
    output logic [CORDW-1:0] by
);

    localparam int unsigned PW = CORDW + 1;

    logic [CORDW-1:0] bx_q, bx_d, by_q, by_d;
    logic             xneg_q, xneg_d, yneg_q, yneg_d;

    // Returns {moving_negative, new_position} for one axis.
    function automatic logic [CORDW:0] bounce(input logic [CORDW-1:0] pos,
                                              input logic             neg,
                                              input logic [CORDW:0]   lim);
        logic [CORDW:0] p;
        p = {1'b0, pos};
        if (!neg) begin
            if (p + PW'(BOX_SIZE) + PW'(BOX_SPEED) > lim) begin
                return {1'b1, CORDW'(lim - PW'(BOX_SIZE))};
            end
            return {1'b0, CORDW'(p + PW'(BOX_SPEED))};
        end
        if (p < PW'(BOX_SPEED)) begin
            return {1'b0, {CORDW{1'b0}}};
        end
        return {1'b1, CORDW'(p - PW'(BOX_SPEED))};
    endfunction

    always_comb begin
        bx_d   = bx_q;
        by_d   = by_q;
        xneg_d = xneg_q;
        yneg_d = yneg_q;
        if (fb) begin
            {xneg_d, bx_d} = bounce(bx_q, xneg_q, PW'(H_RES));
            {yneg_d, by_d} = bounce(by_q, yneg_q, PW'(V_RES));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bx_q   <= '0;
            by_q   <= '0;
            xneg_q <= 1'b0;
            yneg_q <= 1'b0;
        end else begin
            bx_q   <= bx_d;
            by_q   <= by_d;
            xneg_q <= xneg_d;
            yneg_q <= yneg_d;
        end
    end

    assign bx = bx_q;
    assign by = by_q;

endmodule

// File: rtl/test_pattern_gen.sv
// Multi-mode video test pattern generator: two-stage pipeline from timing
// coordinates to registered RGB with delay-matched de/hsync/vsync.
module test_pattern_gen
    import tp_pkg::*;
#(
    parameter int unsigned CORDW      = 11,
    parameter int unsigned CHANW      = 8,
    parameter int unsigned H_RES      = 1280,
    parameter int unsigned V_RES      = 720,
    parameter int unsigned GRAD_SHIFT = 1,
    parameter int unsigned CHK_LOG2   = 5,
    parameter int unsigned GRID_LOG2  = 6,
    parameter int unsigned BOX_SIZE   = 64,
    parameter int unsigned BOX_SPEED  = 4,
    parameter int unsigned FCW        = 16
) (
    input  logic               clk_pix,
    input  logic               rst_pix_n,
    input  logic [CORDW-1:0]   sx,
    input  logic [CORDW-1:0]   sy,
    input  logic               de_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               mode_valid,
    input  logic [2:0]         mode,
    input  logic [3*CHANW-1:0] solid_rgb,
    output logic               mode_busy,
    output logic [2:0]         cur_mode,
    output logic [FCW-1:0]     frame_cnt,
    output logic               de,
    output logic               hsync,
    output logic               vsync,
    output logic [CHANW-1:0]   r,
    output logic [CHANW-1:0]   g,
    output logic [CHANW-1:0]   b
);

    localparam int unsigned PW       = CORDW + 1;
    localparam int unsigned BAR_W    = H_RES / TP_NUM_BARS;
    localparam int unsigned GRAD_LIM = 2 ** (CHANW + GRAD_SHIFT);
    localparam logic [CHANW+7:0] BG_R_X = {TP_BG_RGB[23:16], CHANW'(0)};
    localparam logic [CHANW+7:0] BG_G_X = {TP_BG_RGB[15:8],  CHANW'(0)};
    localparam logic [CHANW+7:0] BG_B_X = {TP_BG_RGB[7:0],   CHANW'(0)};
    localparam logic [CHANW-1:0] BG_R   = BG_R_X[CHANW+7 -: CHANW];
    localparam logic [CHANW-1:0] BG_G   = BG_G_X[CHANW+7 -: CHANW];
    localparam logic [CHANW-1:0] BG_B   = BG_B_X[CHANW+7 -: CHANW];

    logic             fb_c;
    tp_mode_e         cur_mode_q, cur_mode_d, pend_q, pend_d, mode_eff_c;
    logic             busy_q, busy_d;
    logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CORDW-1:0] box_x, box_y;

    logic [CORDW-1:0]   s1_sx_q, s1_sx_d, s1_sy_q, s1_sy_d;
    logic               s1_de_q, s1_de_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
    logic               s1_box_q, s1_box_d;
    tp_mode_e           s1_mode_q, s1_mode_d;
    logic [3*CHANW-1:0] s1_solid_q, s1_solid_d;

    logic               de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic [CHANW-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
    logic [CHANW-1:0]   gx_c, gy_c;
    logic [CORDW-1:0]   bar_c;
    logic [2:0]         bar_idx_c, bar_rgb_c;

    assign fb_c = (sx == '0) && (sy == '0);

    // Mode handshake and frame counter; a pending mode takes effect on the fb pixel
    always_comb begin
        cur_mode_d  = cur_mode_q;
        pend_d      = pend_q;
        busy_d      = busy_q;
        frame_cnt_d = frame_cnt_q;
        mode_eff_c  = cur_mode_q;
        if (fb_c) begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
            if (busy_q) begin
                cur_mode_d = pend_q;
                mode_eff_c = pend_q;
                busy_d     = 1'b0;
            end
        end
        if (mode_valid) begin
            pend_d = tp_mode_e'(mode);
            busy_d = 1'b1;
        end
    end

    tp_box_motion #(
        .CORDW     (CORDW),
        .H_RES     (H_RES),
        .V_RES     (V_RES),
        .BOX_SIZE  (BOX_SIZE),
        .BOX_SPEED (BOX_SPEED)
    ) u_box (
        .clk   (clk_pix),
        .rst_n (rst_pix_n),
        .fb    (fb_c),
        .bx    (box_x),
        .by    (box_y)
    );

    // Stage 1: capture inputs, effective mode and box hit against the pre-update box
    always_comb begin
        s1_sx_d    = sx;
        s1_sy_d    = sy;
        s1_de_d    = de_in;
        s1_hs_d    = hsync_in;
        s1_vs_d    = vsync_in;
        s1_mode_d  = mode_eff_c;
        s1_solid_d = solid_rgb;
        s1_box_d   = (sx >= box_x) && ({1'b0, sx} < ({1'b0, box_x} + PW'(BOX_SIZE)))
                  && (sy >= box_y) && ({1'b0, sy} < ({1'b0, box_y} + PW'(BOX_SIZE)));
    end

    // Stage 2: colour generation
    always_comb begin
        r_d       = '0;
        g_d       = '0;
        b_d       = '0;
        de_d      = s1_de_q;
        hs_d      = s1_hs_q;
        vs_d      = s1_vs_q;
        gx_c      = CHANW'(s1_sx_q >> GRAD_SHIFT);
        gy_c      = CHANW'(s1_sy_q >> GRAD_SHIFT);
        bar_c     = s1_sx_q / CORDW'(BAR_W);
        bar_idx_c = (bar_c > CORDW'(TP_NUM_BARS - 1)) ? 3'd7 : bar_c[2:0];
        bar_rgb_c = TP_BAR_RGB[bar_idx_c];
        case (s1_mode_q)
            TP_GRAD: begin
                if ((32'(s1_sx_q) < GRAD_LIM) && (32'(s1_sy_q) < GRAD_LIM)) begin
                    r_d = gx_c;
                    g_d = gy_c;
                    b_d = ~gy_c;
                end else begin
                    {r_d, g_d, b_d} = {BG_R, BG_G, BG_B};
                end
            end
            TP_BARS: begin
                r_d = {CHANW{bar_rgb_c[2]}};
                g_d = {CHANW{bar_rgb_c[1]}};
                b_d = {CHANW{bar_rgb_c[0]}};
            end
            TP_CHECK: begin
                if (s1_sx_q[CHK_LOG2] ^ s1_sy_q[CHK_LOG2]) begin
                    {r_d, g_d, b_d} = '1;
                end
            end
            TP_GRID: begin
                if ((s1_sx_q[GRID_LOG2-1:0] == '0) || (s1_sy_q[GRID_LOG2-1:0] == '0)
                    || (s1_sx_q == CORDW'(H_RES - 1)) || (s1_sy_q == CORDW'(V_RES - 1))) begin
                    {r_d, g_d, b_d} = '1;
                end
            end
            TP_SOLID: {r_d, g_d, b_d} = s1_solid_q;
            TP_BOX:   {r_d, g_d, b_d} = s1_box_q ? '1 : {BG_R, BG_G, BG_B};
            TP_RAMP:  {r_d, g_d, b_d} = {gx_c, gx_c, gx_c};
            default:  {r_d, g_d, b_d} = '0;
        endcase
        if (!s1_de_q) begin
            {r_d, g_d, b_d} = '0;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            cur_mode_q  <= TP_GRAD;
            pend_q      <= TP_GRAD;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            s1_sx_q     <= '0;
            s1_sy_q     <= '0;
            s1_de_q     <= 1'b0;
            s1_hs_q     <= 1'b0;
            s1_vs_q     <= 1'b0;
            s1_box_q    <= 1'b0;
            s1_mode_q   <= TP_GRAD;
            s1_solid_q  <= '0;
            de_q        <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
        end else begin
            cur_mode_q  <= cur_mode_d;
            pend_q      <= pend_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            s1_sx_q     <= s1_sx_d;
            s1_sy_q     <= s1_sy_d;
            s1_de_q     <= s1_de_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            s1_box_q    <= s1_box_d;
            s1_mode_q   <= s1_mode_d;
            s1_solid_q  <= s1_solid_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
        end
    end

    assign mode_busy = busy_q;
    assign cur_mode  = cur_mode_q;
    assign frame_cnt = frame_cnt_q;
    assign de        = de_q;
    assign hsync     = hs_q;
    assign vsync     = vs_q;
    assign r         = r_q;
    assign g         = g_q;
    assign b         = b_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Bench for test_pattern_gen: behavioural pixel/mode/box model checked every
// cycle, plus directed vectors with hand-computed colours.
module tb_test_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] sx, sy;
    logic        de_in, hsync_in, vsync_in, mode_valid;
    logic [2:0]  mode;
    logic [23:0] solid_rgb;

    logic        mode_busy, de, hsync, vsync;
    logic [2:0]  cur_mode;
    logic [15:0] frame_cnt;
    logic [7:0]  r, g, b;

    logic        mode_busy4, de4, hsync4, vsync4;
    logic [2:0]  cur_mode4;
    logic [3:0]  frame_cnt4;
    logic [7:0]  r4, g4, b4;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    test_pattern_gen u_dut (
        .clk_pix(clk), .rst_pix_n(rst_n), .sx(sx), .sy(sy), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .mode_valid(mode_valid),
        .mode(mode), .solid_rgb(solid_rgb), .mode_busy(mode_busy),
        .cur_mode(cur_mode), .frame_cnt(frame_cnt), .de(de), .hsync(hsync),
        .vsync(vsync), .r(r), .g(g), .b(b)
    );

    test_pattern_gen #(.FCW(4)) u_dut4 (
        .clk_pix(clk), .rst_pix_n(rst_n), .sx(sx), .sy(sy), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .mode_valid(mode_valid),
        .mode(mode), .solid_rgb(solid_rgb), .mode_busy(mode_busy4),
        .cur_mode(cur_mode4), .frame_cnt(frame_cnt4), .de(de4), .hsync(hsync4),
        .vsync(vsync4), .r(r4), .g(g4), .b(b4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Colour a pixel must have, straight from the per-mode rules (1280x720, 8-bit channels)
    function automatic logic [23:0] model_rgb(input int m, input int x, input int y, input bit d,
                                              input logic [23:0] solid, input int bx, input int by);
        logic [23:0] bars [8];
        int bar, v;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        if (!d) return 24'h0;
        case (m)
            0: begin
                if (x < 512 && y < 512)
                    return {8'((x / 2) % 256), 8'((y / 2) % 256), 8'(255 - (y / 2) % 256)};
                return 24'h001133;
            end
            1: begin
                bar = x / 160;
                if (bar > 7) bar = 7;
                return bars[bar];
            end
            2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h0;
            3: return (x % 64 == 0 || y % 64 == 0 || x == 1279 || y == 719) ? 24'hFFFFFF : 24'h0;
            4: return solid;
            5: return (x >= bx && x < bx + 64 && y >= by && y < by + 64) ? 24'hFFFFFF : 24'h001133;
            6: begin
                v = (x / 2) % 256;
                return {8'(v), 8'(v), 8'(v)};
            end
            default: return 24'h0;
        endcase
    endfunction

    function automatic int box_pos(input int p, input int d, input int res);
        if (d > 0) return (p + 64 + 4 > res) ? res - 64 : p + 4;
        return (p < 4) ? 0 : p - 4;
    endfunction

    function automatic int box_dir(input int p, input int d, input int res);
        if (d > 0) return (p + 64 + 4 > res) ? -1 : 1;
        return (p < 4) ? 1 : -1;
    endfunction

    int          m_cur, m_pend, m_fcnt, m_bx, m_by, m_dx, m_dy, m_eff;
    int          bx_n, by_n, dx_n, dy_n;
    bit          m_busy, m_fb;
    logic [23:0] m_pix;
    logic [26:0] m_s1, m_s2;

    always_comb begin
        m_fb  = (sx == 11'd0) && (sy == 11'd0);
        m_eff = (m_fb && m_busy) ? m_pend : m_cur;
        m_pix = model_rgb(m_eff, int'(sx), int'(sy), de_in, solid_rgb, m_bx, m_by);
        bx_n  = box_pos(m_bx, m_dx, 1280);
        dx_n  = box_dir(m_bx, m_dx, 1280);
        by_n  = box_pos(m_by, m_dy, 720);
        dy_n  = box_dir(m_by, m_dy, 720);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cur <= 0; m_pend <= 0; m_busy <= 1'b0; m_fcnt <= 0;
            m_bx <= 0; m_by <= 0; m_dx <= 1; m_dy <= 1;
            m_s1 <= '0; m_s2 <= '0;
        end else begin
            m_s1 <= {de_in, hsync_in, vsync_in, m_pix};
            m_s2 <= m_s1;
            if (m_fb) begin
                m_fcnt <= m_fcnt + 1;
                m_bx <= bx_n; m_dx <= dx_n; m_by <= by_n; m_dy <= dy_n;
                if (m_busy) begin
                    m_cur  <= m_pend;
                    m_busy <= 1'b0;
                end
            end
            if (mode_valid) begin
                m_pend <= int'(mode);
                m_busy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("pix_out", 64'({de, hsync, vsync, r, g, b}), 64'(m_s2));
            check("pix_out_fcw4", 64'({de4, hsync4, vsync4, r4, g4, b4}), 64'(m_s2));
            check("cur_mode", 64'(cur_mode), 64'(m_cur));
            check("cur_mode_fcw4", 64'(cur_mode4), 64'(m_cur));
            check("mode_busy", 64'(mode_busy), 64'(m_busy));
            check("mode_busy_fcw4", 64'(mode_busy4), 64'(m_busy));
            check("frame_cnt", 64'(frame_cnt), 64'(m_fcnt % 65536));
            check("frame_cnt_fcw4", 64'(frame_cnt4), 64'(m_fcnt % 16));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int y, input bit d);
        sx       = 11'(x);
        sy       = 11'(y);
        de_in    = d;
        hsync_in = x[1];
        vsync_in = y[1];
    endtask

    task automatic pix(input string name, input int x, input int y, input bit d, input logic [23:0] exp);
        drive(x, y, d);
        step();
        step();
        check(name, 64'({r, g, b}), 64'(exp));
    endtask

    task automatic req(input int m);
        mode       = 3'(m);
        mode_valid = 1'b1;
        step();
        mode_valid = 1'b0;
    endtask

    task automatic fb_pulse();
        drive(0, 0, 1'b1);
        step();
        drive(5, 5, 1'b1);
        step();
    endtask

    task automatic switch_mode(input int m);
        drive(5, 5, 1'b1);
        req(m);
        fb_pulse();
    endtask

    initial begin
        rst_n = 1'b1; mode_valid = 1'b0; mode = 3'd0; solid_rgb = 24'h123456;
        drive(5, 5, 1'b0);
        #2 rst_n = 1'b0;
        started = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb", 64'({de, r, g, b}), 64'(0));
        check("reset_frame_cnt", 64'(frame_cnt), 64'(0));
        #2 rst_n = 1'b1;
        step();

        // two-cycle latency, gradient and its background
        drive(10, 20, 1'b1);
        step();
        check("latency_one_cycle", 64'({de, r, g, b}), 64'(0));
        step();
        check("grad_rgb", 64'({r, g, b}), 64'(24'h050AF5));
        check("grad_de", 64'(de), 64'(1));
        pix("grad_bg", 600, 20, 1'b1, 24'h001133);

        // switch to bars; applied at the fb pixel
        drive(5, 5, 1'b1);
        req(1);
        check("busy_set", 64'(mode_busy), 64'(1));
        check("mode_held", 64'(cur_mode), 64'(0));
        drive(0, 0, 1'b1);
        step();
        check("mode_applied", 64'(cur_mode), 64'(1));
        check("busy_clr", 64'(mode_busy), 64'(0));
        check("frame_cnt_1", 64'(frame_cnt), 64'(1));
        drive(5, 5, 1'b1);
        step();
        check("fb_pixel_new_mode", 64'({r, g, b}), 64'(24'hFFFFFF));
        pix("bar0_edge", 159, 5, 1'b1, 24'hFFFFFF);
        pix("bar1_start", 160, 5, 1'b1, 24'hFFFF00);
        pix("bar5", 800, 5, 1'b1, 24'hFF0000);
        pix("bar7_last", 1279, 5, 1'b1, 24'h000000);
        pix("bar_blank", 160, 5, 1'b0, 24'h000000);

        // last request wins
        drive(300, 5, 1'b1);
        req(2);
        check("busy_req2", 64'(mode_busy), 64'(1));
        check("mode_held_req2", 64'(cur_mode), 64'(1));
        req(3);
        check("mode_held_req3", 64'(cur_mode), 64'(1));
        drive(0, 0, 1'b1);
        step();
        check("last_req_wins", 64'(cur_mode), 64'(3));
        drive(5, 5, 1'b1);
        step();
        pix("grid_x64", 64, 5, 1'b1, 24'hFFFFFF);
        pix("grid_off", 65, 5, 1'b1, 24'h000000);
        pix("grid_right", 1279, 5, 1'b1, 24'hFFFFFF);
        pix("grid_bottom", 65, 719, 1'b1, 24'hFFFFFF);
        pix("grid_y128", 65, 128, 1'b1, 24'hFFFFFF);

        // request on the fb cycle is deferred one frame
        drive(0, 0, 1'b1);
        mode = 3'd2; mode_valid = 1'b1;
        step();
        mode_valid = 1'b0;
        check("fb_req_deferred", 64'(cur_mode), 64'(3));
        check("fb_req_pending", 64'(mode_busy), 64'(1));
        drive(5, 5, 1'b1);
        step();
        drive(0, 0, 1'b1);
        step();
        check("fb_req_applied", 64'(cur_mode), 64'(2));
        drive(5, 5, 1'b1);
        step();
        pix("check_white", 32, 3, 1'b1, 24'hFFFFFF);
        pix("check_both", 32, 32, 1'b1, 24'h000000);
        pix("check_y", 0, 40, 1'b1, 24'hFFFFFF);
        pix("check_black", 31, 5, 1'b1, 24'h000000);

        switch_mode(4);
        pix("solid", 7, 9, 1'b1, 24'h123456);
        switch_mode(6);
        pix("ramp", 300, 1, 1'b1, 24'h969696);
        pix("ramp_top", 511, 1, 1'b1, 24'hFFFFFF);
        pix("ramp_trunc", 512, 1, 1'b1, 24'h000000);
        switch_mode(7);
        pix("reserved", 300, 1, 1'b1, 24'h000000);
        switch_mode(0);
        pix("grad_pre_reset", 10, 22, 1'b1, 24'h050BF4);
        check("syncs_pass", 64'({de, hsync, vsync}), 64'(3'b111));

        // async reset mid-frame
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_out", 64'({de, hsync, vsync, r, g, b}), 64'(0));
        check("async_reset_cnt", 64'({cur_mode, mode_busy, frame_cnt}), 64'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // bouncing box across the right edge
        switch_mode(5);
        repeat (303) fb_pulse();
        check("frame_cnt_304", 64'(frame_cnt), 64'(304));
        pix("box_in_304", 1216, 100, 1'b1, 24'hFFFFFF);
        pix("box_left_304", 1215, 100, 1'b1, 24'h001133);
        pix("box_corner_304", 1279, 163, 1'b1, 24'hFFFFFF);
        pix("box_below_304", 1279, 164, 1'b1, 24'h001133);
        fb_pulse();
        check("frame_cnt_305", 64'(frame_cnt), 64'(305));
        check("frame_cnt4_305", 64'(frame_cnt4), 64'(1));
        pix("box_hold_305", 1216, 96, 1'b1, 24'hFFFFFF);
        pix("box_left_305", 1215, 96, 1'b1, 24'h001133);
        fb_pulse();
        pix("box_rev_306", 1212, 92, 1'b1, 24'hFFFFFF);
        pix("box_left_306", 1211, 92, 1'b1, 24'h001133);
        pix("box_right_306", 1276, 92, 1'b1, 24'h001133);
        repeat (13) fb_pulse();
        check("frame_cnt4_max", 64'(frame_cnt4), 64'(15));
        fb_pulse();
        check("frame_cnt4_wrap", 64'(frame_cnt4), 64'(0));
        check("frame_cnt_320", 64'(frame_cnt), 64'(320));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
